// File: rtl/pn_gain_ctrl.sv
// pn_gain_ctrl
//   Automatic gain control loop for the gain-shift slice stage. The block
//   tracks the peak magnitude of the scaled samples over a window. At the
//   end of each window it steps the gain select down when the peak is too
//   large and up when the peak is too small. A coarse ACQ mode uses short
//   windows. A TRACK mode, entered once the level has settled, uses long
//   windows.
//
// Ports
//   clk       sole clock, rising edge
//   rst       synchronous active-high reset
//   DinValid  qualifies Din for one cycle
//   Din       signed scaled sample (OutWdth bits)
//   Freeze    hold GCtrl while still evaluating windows
//   GCtrl     registered 4-bit gain select (higher value = more gain)
//   GUpd      one-cycle pulse whenever GCtrl changes
//   Locked    high while in TRACK
module pn_gain_ctrl #(
  parameter int OutWdth = 24,
  parameter int WinLen  = 1024,
  parameter int HiThr   = 4194304,
  parameter int LoThr   = 1048576,
  parameter int GInit   = 8,
  parameter int Blank   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      DinValid,
  input  logic signed [OutWdth-1:0] Din,
  input  logic                      Freeze,
  output logic [3:0]                GCtrl,
  output logic                      GUpd,
  output logic                      Locked
);

  localparam int WinW = $clog2(WinLen);
  localparam int BlkW = (Blank < 2) ? 1 : $clog2(Blank + 1);

  localparam logic [WinW-1:0]    AcqLast = WinW'(WinLen / 8 - 1);
  localparam logic [WinW-1:0]    TrkLast = WinW'(WinLen - 1);
  localparam logic [OutWdth-1:0] HiThrV  = OutWdth'(HiThr);
  localparam logic [OutWdth-1:0] LoThrV  = OutWdth'(LoThr);
  localparam logic [OutWdth-1:0] MinVal  = {1'b1, {(OutWdth-1){1'b0}}};
  localparam logic [OutWdth-1:0] MaxMag  = {1'b0, {(OutWdth-1){1'b1}}};

  typedef enum logic {StAcq, StTrack} state_e;
  typedef enum logic [1:0] {DecHold, DecUp, DecDown} dec_e;

  state_e            state_q, state_d;
  logic [3:0]        gCtrl_q, gCtrl_d;
  logic              gUpd_q, gUpd_d;
  logic              locked_q, locked_d;
  logic [OutWdth-1:0] peak_q, peak_d;
  logic [WinW-1:0]   winCnt_q, winCnt_d;
  logic [BlkW-1:0]   blank_q, blank_d;
  logic              pend_q, pend_d;
  logic              holdRun_q, holdRun_d;
  logic [1:0]        moveRun_q, moveRun_d;

  logic [OutWdth-1:0] mag;
  logic [WinW-1:0]    winLast;
  logic               blankLoad;
  dec_e               rawDec, effDec;

  // Next-state logic. A window end only raises pend_q, so the decision is
  // taken on the following edge from the registered peak. That same edge
  // restarts the window, which lets a sample arriving on the decision cycle
  // open the new window.
  always_comb begin
    mag       = '0;
    winLast   = (state_q == StTrack) ? TrkLast : AcqLast;
    blankLoad = 1'b0;
    rawDec    = DecHold;
    effDec    = DecHold;
    state_d   = state_q;
    gCtrl_d   = gCtrl_q;
    gUpd_d    = 1'b0;
    locked_d  = locked_q;
    peak_d    = peak_q;
    winCnt_d  = winCnt_q;
    blank_d   = blank_q;
    pend_d    = pend_q;
    holdRun_d = holdRun_q;
    moveRun_d = moveRun_q;

    // The most negative input has no positive twin, so it saturates.
    if (!Din[OutWdth-1]) begin
      mag = $unsigned(Din);
    end else if ($unsigned(Din) == MinVal) begin
      mag = MaxMag;
    end else begin
      mag = $unsigned(-Din);
    end

    if (peak_q >= HiThrV) begin
      rawDec = DecDown;
    end else if (peak_q < LoThrV) begin
      rawDec = DecUp;
    end

    // The gain select saturates at both ends instead of wrapping.
    effDec = rawDec;
    if ((rawDec == DecDown && gCtrl_q == 4'd0) ||
        (rawDec == DecUp && gCtrl_q == 4'd15)) begin
      effDec = DecHold;
    end

    if (pend_q) begin
      pend_d   = 1'b0;
      peak_d   = '0;
      winCnt_d = '0;

      if (!Freeze && effDec != DecHold) begin
        gCtrl_d   = (effDec == DecUp) ? gCtrl_q + 4'd1 : gCtrl_q - 4'd1;
        gUpd_d    = 1'b1;
        blankLoad = 1'b1;
      end

      // Mode changes ignore Freeze, so the loop still reports loss of lock.
      if (state_q == StAcq) begin
        if (effDec == DecHold) begin
          if (holdRun_q) begin
            state_d   = StTrack;
            locked_d  = 1'b1;
            holdRun_d = 1'b0;
            moveRun_d = '0;
          end else begin
            holdRun_d = 1'b1;
          end
        end else begin
          holdRun_d = 1'b0;
        end
      end else begin
        if (effDec != DecHold) begin
          if (moveRun_q == 2'd2) begin
            state_d   = StAcq;
            locked_d  = 1'b0;
            holdRun_d = 1'b0;
            moveRun_d = '0;
          end else begin
            moveRun_d = moveRun_q + 2'd1;
          end
        end else begin
          moveRun_d = '0;
        end
      end
    end

    // While blanking, valid samples only decrement the blanking counter.
    if (DinValid) begin
      if (blank_q != '0) begin
        blank_d = blank_q - 1'b1;
      end else begin
        if (mag > peak_d) begin
          peak_d = mag;
        end
        if (winCnt_d == winLast) begin
          pend_d   = 1'b1;
          winCnt_d = '0;
        end else begin
          winCnt_d = winCnt_d + 1'b1;
        end
      end
    end

    if (blankLoad) begin
      blank_d = BlkW'(Blank);
    end
  end

  // State register. Reset has priority over every pending action.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StAcq;
      gCtrl_q   <= 4'(GInit);
      gUpd_q    <= 1'b0;
      locked_q  <= 1'b0;
      peak_q    <= '0;
      winCnt_q  <= '0;
      blank_q   <= '0;
      pend_q    <= 1'b0;
      holdRun_q <= 1'b0;
      moveRun_q <= '0;
    end else begin
      state_q   <= state_d;
      gCtrl_q   <= gCtrl_d;
      gUpd_q    <= gUpd_d;
      locked_q  <= locked_d;
      peak_q    <= peak_d;
      winCnt_q  <= winCnt_d;
      blank_q   <= blank_d;
      pend_q    <= pend_d;
      holdRun_q <= holdRun_d;
      moveRun_q <= moveRun_d;
    end
  end

  assign GCtrl  = gCtrl_q;
  assign GUpd   = gUpd_q;
  assign Locked = locked_q;

endmodule

// File: tb/tb_pn_gain_ctrl.sv
// tb_pn_gain_ctrl
//   Self-checking bench for pn_gain_ctrl with WinLen=64 (ACQ window 8) and
//   Blank=4. Each scenario pushes the expected new gain and the cycle of
//   its GUpd pulse at the moment the window-closing sample is driven. A
//   monitor pops these entries whenever GUpd is seen.
module tb_pn_gain_ctrl;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               DinValid = 1'b0;
  logic signed [23:0] Din = '0;
  logic               Freeze = 1'b0;
  logic [3:0]         GCtrl;
  logic               GUpd;
  logic               Locked;

  typedef struct {
    int gain;
    int cyc;
  } exp_t;

  exp_t sbQ[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  pn_gain_ctrl #(
    .OutWdth(24),
    .WinLen(64),
    .HiThr(4194304),
    .LoThr(1048576),
    .GInit(8),
    .Blank(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .DinValid(DinValid),
    .Din(Din),
    .Freeze(Freeze),
    .GCtrl(GCtrl),
    .GUpd(GUpd),
    .Locked(Locked)
  );

  // Free-running clock and an edge counter used to time GUpd pulses
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs just after an edge, return after the next edge
  task automatic applyStimulus(input logic v, input int d, input logic f);
    DinValid = v;
    Din      = 24'(d);
    Freeze   = f;
    @(posedge clk);
    #1;
  endtask

  // Called right after the window-closing sample: GCtrl moves one edge later
  task automatic expectGain(input int g);
    exp_t e;
    e.gain = g;
    e.cyc  = cyc + 1;
    sbQ.push_back(e);
  endtask

  task automatic resetDut();
    rst = 1'b1;
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("rst_gctrl", int'(GCtrl), 8);
    checkOutput("rst_gupd", int'(GUpd), 0);
    checkOutput("rst_locked", int'(Locked), 0);
    rst = 1'b0;
  endtask

  task automatic drainCheck(input string tag);
    applyStimulus(1'b0, 0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput(tag, sbQ.size(), 0);
    sbQ.delete();
  endtask

  // Scoreboard monitor: every GUpd pulse must match a queued expectation
  always @(negedge clk) begin
    if (!rst && GUpd === 1'b1) begin
      if (sbQ.size() == 0) begin
        checkOutput("gupd_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput("gupd_gain", int'(GCtrl), e.gain);
        checkOutput("gupd_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Large peak steps down, then the 4 following samples are blanked, so
    // the second window closes on the 20th sample rather than the 16th
    resetDut();
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(1'b1, 6000000, 1'b0);
      if (i == 8)  expectGain(7);
      if (i == 20) expectGain(6);
    end
    drainCheck("s1_drain");
    checkOutput("s1_gctrl", int'(GCtrl), 6);
    checkOutput("s1_locked", int'(Locked), 0);

    // Two HOLD windows lock the loop, after which windows are 64 long
    resetDut();
    for (int i = 1; i <= 16; i++) applyStimulus(1'b1, 2000000, 1'b0);
    checkOutput("s2_prelock", int'(Locked), 0);
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("s2_locked", int'(Locked), 1);
    checkOutput("s2_gctrl", int'(GCtrl), 8);
    for (int i = 1; i <= 64; i++) begin
      applyStimulus(1'b1, 6000000, 1'b0);
      if (i == 64) expectGain(7);
    end
    drainCheck("s2_drain");
    checkOutput("s2_still_locked", int'(Locked), 1);

    // Small signal climbs to 15 and saturates there, then locks
    resetDut();
    for (int i = 1; i <= 110; i++) begin
      applyStimulus(1'b1, 1000, 1'b0);
      if (i >= 8 && i <= 80 && (i - 8) % 12 == 0) expectGain(9 + (i - 8) / 12);
      if (i == 100) checkOutput("s3_prelock", int'(Locked), 0);
      if (i == 101) checkOutput("s3_locked", int'(Locked), 1);
    end
    drainCheck("s3_drain");
    checkOutput("s3_gctrl_sat", int'(GCtrl), 15);

    // Most negative sample alone must read as a full-scale peak
    resetDut();
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, (i == 4) ? -8388608 : 0, 1'b0);
      if (i == 8) expectGain(7);
    end
    drainCheck("s4_drain");

    // Negative sample exactly at the high threshold also steps down
    resetDut();
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, -4194304, 1'b0);
      if (i == 8) expectGain(7);
    end
    drainCheck("s7_drain");

    // Peak at LoThr or just under HiThr holds; an invalid large sample is
    // ignored; the next window just under LoThr steps up
    resetDut();
    applyStimulus(1'b1, 1048576, 1'b0);
    applyStimulus(1'b0, 6000000, 1'b0);
    applyStimulus(1'b1, 4194303, 1'b0);
    for (int i = 1; i <= 6; i++) applyStimulus(1'b1, 1048576, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 1048575, 1'b0);
      if (i == 8) expectGain(9);
    end
    drainCheck("s8_drain");

    // Freeze in TRACK: gain held, three UP decisions drop lock, then the
    // next window already uses the short ACQ length
    resetDut();
    for (int i = 1; i <= 16; i++) applyStimulus(1'b1, 2000000, 1'b0);
    applyStimulus(1'b0, 0, 1'b0);
    checkOutput("s5_locked", int'(Locked), 1);
    for (int i = 1; i <= 200; i++) begin
      applyStimulus(1'b1, 100, (i <= 193) ? 1'b1 : 1'b0);
      if (i == 192) checkOutput("s5_before_unlock", int'(Locked), 1);
      if (i == 193) begin
        checkOutput("s5_unlocked", int'(Locked), 0);
        checkOutput("s5_frozen_gctrl", int'(GCtrl), 8);
      end
      if (i == 200) expectGain(9);
    end
    drainCheck("s5_drain");

    // Reset mid-window clears window progress and peak
    resetDut();
    for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 6000000, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b1, 6000000, 1'b1);
    checkOutput("s6_gctrl", int'(GCtrl), 8);
    checkOutput("s6_gupd", int'(GUpd), 0);
    checkOutput("s6_locked", int'(Locked), 0);
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 2000000, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 6000000, 1'b0);
      if (i == 8) expectGain(7);
    end
    drainCheck("s6_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
